// File: rtl/seq_muldiv.sv
// Multi-cycle multiply/divide unit beside the combinational ALU: shift-add multiplier
// and restoring divider on operand magnitudes, with a final sign-fix cycle.
package seq_muldiv_pkg;
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLTU = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9,
        ALU_MUL  = 4'd10,
        ALU_DIV  = 4'd11,
        ALU_MOD  = 4'd12
    } e_alu_op;
endpackage

module seq_muldiv
    import seq_muldiv_pkg::*;
#(
    parameter int WORD = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  e_alu_op         op,
    input  logic            sign,
    input  logic [WORD-1:0] a,
    input  logic [WORD-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [WORD-1:0] r,
    output logic [WORD-1:0] r_high,
    output logic            div_zero,
    output logic            overflow,
    output logic            illegal
);

    localparam int CW = $clog2(WORD) + 1;
    localparam logic [CW-1:0]   LAST_ITER = CW'(WORD - 1);
    localparam logic [WORD-1:0] MIN_NEG   = {1'b1, {(WORD-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } e_state;

    e_state state_q, state_d;

    e_alu_op         op_q, op_d;
    logic            sign_q, sign_d;
    logic            neg_quot_q, neg_quot_d;
    logic            neg_rem_q, neg_rem_d;
    logic            b_zero_q, b_zero_d;
    logic            div_ovf_q, div_ovf_d;
    logic [WORD-1:0] a_orig_q, a_orig_d;
    logic [WORD-1:0] m_q, m_d;
    logic [WORD-1:0] hi_q, hi_d;
    logic [WORD-1:0] lo_q, lo_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [WORD-1:0] r_q, r_d;
    logic [WORD-1:0] r_high_q, r_high_d;
    logic            div_zero_q, div_zero_d;
    logic            overflow_q, overflow_d;
    logic            illegal_q, illegal_d;

    logic            op_legal;
    logic [WORD-1:0] a_abs, b_abs;
    logic [WORD:0]   mul_sum;
    logic [WORD:0]   rem_sh, rem_diff;
    logic [2*WORD-1:0] prod, prod_s;
    logic [WORD-1:0] quot_s, rem_s;
    logic            mul_ovf;

    assign op_legal = (op == ALU_MUL) || (op == ALU_DIV) || (op == ALU_MOD);

    // Magnitudes: the most negative value maps to 2^(WORD-1), still fits unsigned.
    assign a_abs = (sign && a[WORD-1]) ? -a : a;
    assign b_abs = (sign && b[WORD-1]) ? -b : b;

    assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
    assign rem_sh   = {hi_q, lo_q[WORD-1]};
    assign rem_diff = rem_sh - {1'b0, m_q};

    assign prod    = {hi_q, lo_q};
    assign prod_s  = neg_quot_q ? -prod : prod;
    assign quot_s  = neg_quot_q ? -lo_q : lo_q;
    assign rem_s   = neg_rem_q ? -hi_q : hi_q;
    assign mul_ovf = sign_q ? (prod_s[2*WORD-1:WORD] != {WORD{prod_s[WORD-1]}})
                            : (prod_s[2*WORD-1:WORD] != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (in_valid) state_d = op_legal ? S_CALC : S_FIX;
            S_CALC: if (cnt_q == LAST_ITER) state_d = S_FIX;
            S_FIX:  state_d = S_DONE;
            S_DONE: if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);
    end

    always_comb begin
        op_d       = op_q;
        sign_d     = sign_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        b_zero_d   = b_zero_q;
        div_ovf_d  = div_ovf_q;
        a_orig_d   = a_orig_q;
        m_d        = m_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        cnt_d      = cnt_q;
        r_d        = r_q;
        r_high_d   = r_high_q;
        div_zero_d = div_zero_q;
        overflow_d = overflow_q;
        illegal_d  = illegal_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    op_d       = op;
                    sign_d     = sign;
                    neg_quot_d = sign & (a[WORD-1] ^ b[WORD-1]);
                    neg_rem_d  = sign & a[WORD-1];
                    b_zero_d   = (b == '0);
                    div_ovf_d  = sign && (a == MIN_NEG) && (b == '1);
                    a_orig_d   = a;
                    hi_d       = '0;
                    cnt_d      = '0;
                    // Multiplier sits in lo and shifts out; dividend sits in lo and shifts into rem.
                    if (op == ALU_MUL) begin
                        m_d  = a_abs;
                        lo_d = b_abs;
                    end else begin
                        m_d  = b_abs;
                        lo_d = a_abs;
                    end
                end
            end
            S_CALC: begin
                cnt_d = cnt_q + 1'b1;
                if (op_q == ALU_MUL) begin
                    hi_d = mul_sum[WORD:1];
                    lo_d = {mul_sum[0], lo_q[WORD-1:1]};
                end else if (!rem_diff[WORD]) begin
                    hi_d = rem_diff[WORD-1:0];
                    lo_d = {lo_q[WORD-2:0], 1'b1};
                end else begin
                    hi_d = rem_sh[WORD-1:0];
                    lo_d = {lo_q[WORD-2:0], 1'b0};
                end
            end
            S_FIX: begin
                div_zero_d = 1'b0;
                overflow_d = 1'b0;
                illegal_d  = 1'b0;
                case (op_q)
                    ALU_MUL: begin
                        r_d        = prod_s[WORD-1:0];
                        r_high_d   = prod_s[2*WORD-1:WORD];
                        overflow_d = mul_ovf;
                    end
                    ALU_DIV, ALU_MOD: begin
                        if (b_zero_q) begin
                            r_d        = (op_q == ALU_DIV) ? '1 : a_orig_q;
                            r_high_d   = (op_q == ALU_DIV) ? a_orig_q : '1;
                            div_zero_d = 1'b1;
                        end else begin
                            r_d        = (op_q == ALU_DIV) ? quot_s : rem_s;
                            r_high_d   = (op_q == ALU_DIV) ? rem_s : quot_s;
                            overflow_d = div_ovf_q;
                        end
                    end
                    default: begin
                        r_d       = '0;
                        r_high_d  = '0;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q       <= ALU_ADD;
            sign_q     <= 1'b0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            b_zero_q   <= 1'b0;
            div_ovf_q  <= 1'b0;
            a_orig_q   <= '0;
            m_q        <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            cnt_q      <= '0;
            r_q        <= '0;
            r_high_q   <= '0;
            div_zero_q <= 1'b0;
            overflow_q <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            op_q       <= op_d;
            sign_q     <= sign_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            b_zero_q   <= b_zero_d;
            div_ovf_q  <= div_ovf_d;
            a_orig_q   <= a_orig_d;
            m_q        <= m_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            cnt_q      <= cnt_d;
            r_q        <= r_d;
            r_high_q   <= r_high_d;
            div_zero_q <= div_zero_d;
            overflow_q <= overflow_d;
            illegal_q  <= illegal_d;
        end
    end

    assign r        = r_q;
    assign r_high   = r_high_q;
    assign div_zero = div_zero_q;
    assign overflow = overflow_q;
    assign illegal  = illegal_q;

endmodule

// File: tb/tb_seq_muldiv.sv
// Bench for seq_muldiv: 8- and 16-bit instances checked against an integer-arithmetic
// reference model with directed, back-pressure, mid-operation reset and random requests.
module tb_seq_muldiv;
    import seq_muldiv_pkg::*;

    logic clk = 1'b0;
    logic rst_n;

    logic       in_valid8, out_ready8, sign8, in_ready8, out_valid8, dz8, ov8, il8;
    e_alu_op    op8;
    logic [7:0] a8, b8, r8, rh8;

    logic        in_valid16, out_ready16, sign16, in_ready16, out_valid16, dz16, ov16, il16;
    e_alu_op     op16;
    logic [15:0] a16, b16, r16, rh16;

    int checks;
    int failures;
    string currentCase;

    always #5 clk = ~clk;

    seq_muldiv #(.WORD(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .op(op8), .sign(sign8), .a(a8), .b(b8), .out_valid(out_valid8),
        .out_ready(out_ready8), .r(r8), .r_high(rh8), .div_zero(dz8),
        .overflow(ov8), .illegal(il8)
    );

    seq_muldiv #(.WORD(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
        .op(op16), .sign(sign16), .a(a16), .b(b16), .out_valid(out_valid16),
        .out_ready(out_ready16), .r(r16), .r_high(rh16), .div_zero(dz16),
        .overflow(ov16), .illegal(il16)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s %s: got=0x%0h expected=0x%0h", currentCase, tag, got, exp);
        end
    endtask

    function automatic void model(input int w, input int opv, input bit sg,
                                  input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] er, output logic [15:0] erh,
                                  output bit edz, output bit eov, output bit eil);
        longint lim, mask, va, vb, p, q, m;
        lim  = longint'(1) << w;
        mask = lim - 1;
        va   = longint'(a);
        vb   = longint'(b);
        if (sg && a[w-1]) va = va - lim;
        if (sg && b[w-1]) vb = vb - lim;
        er = '0; erh = '0; edz = 0; eov = 0; eil = 0;
        if (opv == int'(ALU_MUL)) begin
            p   = va * vb;
            er  = 16'(p & mask);
            erh = 16'((p >>> w) & mask);
            eov = sg ? (p < -(lim / 2) || p >= lim / 2) : (p >= lim);
        end else if (opv == int'(ALU_DIV) || opv == int'(ALU_MOD)) begin
            if (vb == 0) begin
                q = mask; m = longint'(a); edz = 1;
            end else if (sg && va == -(lim / 2) && vb == -1) begin
                q = lim / 2; m = 0; eov = 1;
            end else begin
                q = va / vb; m = va % vb;
            end
            if (opv == int'(ALU_DIV)) begin
                er = 16'(q & mask); erh = 16'(m & mask);
            end else begin
                er = 16'(m & mask); erh = 16'(q & mask);
            end
        end else begin
            eil = 1;
        end
    endfunction

    task automatic driveInputs(input int w, input bit v, input int opv, input bit sg,
                               input logic [15:0] a, input logic [15:0] b);
        if (w == 8) begin
            in_valid8 = v; op8 = e_alu_op'(opv[3:0]); sign8 = sg; a8 = a[7:0]; b8 = b[7:0];
        end else begin
            in_valid16 = v; op16 = e_alu_op'(opv[3:0]); sign16 = sg; a16 = a; b16 = b;
        end
    endtask

    task automatic setOutReady(input int w, input bit v);
        if (w == 8) out_ready8 = v;
        else out_ready16 = v;
    endtask

    task automatic readOutputs(input int w, output logic vld, output logic rdy,
                               output logic [15:0] rr, output logic [15:0] rh,
                               output logic dz, output logic of, output logic il);
        if (w == 8) begin
            vld = out_valid8; rdy = in_ready8; rr = {8'h00, r8}; rh = {8'h00, rh8};
            dz = dz8; of = ov8; il = il8;
        end else begin
            vld = out_valid16; rdy = in_ready16; rr = r16; rh = rh16;
            dz = dz16; of = ov16; il = il16;
        end
    endtask

    task automatic checkResult(input int w, input int opv, input bit sg,
                               input logic [15:0] a, input logic [15:0] b);
        logic [15:0] er, erh, rr, rh;
        bit edz, eov, eil;
        logic vld, rdy, dz, of, il;
        model(w, opv, sg, a, b, er, erh, edz, eov, eil);
        readOutputs(w, vld, rdy, rr, rh, dz, of, il);
        checkOutput("out_valid", vld, 1);
        checkOutput("r", rr, er);
        checkOutput("r_high", rh, erh);
        checkOutput("flags{dz,ov,il}", {dz, of, il}, {edz, eov, eil});
    endtask

    // Starts at 1 time unit after an edge; waits for the result with a bounded cycle budget.
    task automatic waitResult(input int w, input int expLat);
        logic [15:0] rr, rh;
        logic vld, rdy, dz, of, il;
        int edges;
        edges = 1;
        readOutputs(w, vld, rdy, rr, rh, dz, of, il);
        checkOutput("in_ready_busy", rdy, 0);
        while (!vld && edges < 100) begin
            @(posedge clk); #1;
            edges++;
            readOutputs(w, vld, rdy, rr, rh, dz, of, il);
        end
        checkOutput("latency", edges, expLat);
    endtask

    task automatic retire(input int w);
        logic [15:0] rr, rh;
        logic vld, rdy, dz, of, il;
        setOutReady(w, 1);
        @(posedge clk); #1;
        setOutReady(w, 0);
        readOutputs(w, vld, rdy, rr, rh, dz, of, il);
        checkOutput("retire_valid", vld, 0);
        checkOutput("retire_ready", rdy, 1);
    endtask

    task automatic applyStimulus(input int w, input int opv, input bit sg,
                                 input logic [15:0] a, input logic [15:0] b, input int holdCycles);
        logic [15:0] rr, rh;
        logic vld, rdy, dz, of, il;
        int expLat;
        bit legal;
        currentCase = $sformatf("w%0d op%0d s%0d a=%0h b=%0h", w, opv, sg, a, b);
        legal  = (opv == int'(ALU_MUL)) || (opv == int'(ALU_DIV)) || (opv == int'(ALU_MOD));
        expLat = legal ? w + 2 : 2;
        readOutputs(w, vld, rdy, rr, rh, dz, of, il);
        checkOutput("in_ready_idle", rdy, 1);
        driveInputs(w, 1, opv, sg, a, b);
        @(posedge clk); #1;
        driveInputs(w, 0, int'(ALU_ADD), 0, 16'h0, 16'h0);
        waitResult(w, expLat);
        checkResult(w, opv, sg, a, b);
        if (holdCycles > 0) begin
            repeat (holdCycles) begin @(posedge clk); #1; end
            checkResult(w, opv, sg, a, b);
        end
        retire(w);
    endtask

    function automatic logic [15:0] pickOperand(input int w);
        logic [15:0] mask, v;
        mask = 16'((32'd1 << w) - 1);
        case ($urandom_range(0, 7))
            0: v = 16'h0;
            1: v = 16'(32'd1 << (w - 1));
            2: v = mask;
            3: v = 16'd1;
            default: v = 16'($urandom) & mask;
        endcase
        return v;
    endfunction

    function automatic int pickOp();
        int k;
        k = int'($urandom_range(0, 9));
        if (k < 3) return int'(ALU_MUL);
        if (k < 6) return int'(ALU_DIV);
        if (k < 9) return int'(ALU_MOD);
        return (($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 9)) : int'($urandom_range(13, 15)));
    endfunction

    initial begin
        logic [15:0] rr, rh;
        logic vld, rdy, dz, of, il;
        int w;

        checks = 0;
        failures = 0;
        currentCase = "reset";
        rst_n = 1'b0;
        driveInputs(8, 0, int'(ALU_ADD), 0, 16'h0, 16'h0);
        driveInputs(16, 0, int'(ALU_ADD), 0, 16'h0, 16'h0);
        out_ready8 = 1'b0;
        out_ready16 = 1'b0;

        #2;
        foreach (rr[i]) begin end
        for (int k = 0; k < 2; k++) begin
            w = (k == 0) ? 8 : 16;
            readOutputs(w, vld, rdy, rr, rh, dz, of, il);
            checkOutput("rst_in_ready", rdy, 1);
            checkOutput("rst_out_valid", vld, 0);
            checkOutput("rst_r", rr, 0);
            checkOutput("rst_r_high", rh, 0);
            checkOutput("rst_flags", {dz, of, il}, 3'b000);
        end
        #21 rst_n = 1'b1;
        @(posedge clk); #1;

        applyStimulus(8, int'(ALU_MUL), 0, 16'd5, 16'd8, 0);
        applyStimulus(8, int'(ALU_MUL), 0, 16'd200, 16'd200, 0);
        applyStimulus(8, int'(ALU_MUL), 1, 16'h00FB, 16'd8, 0);
        applyStimulus(8, int'(ALU_MUL), 1, 16'h0080, 16'h00FF, 0);
        applyStimulus(8, int'(ALU_DIV), 0, 16'd65, 16'd4, 0);
        applyStimulus(8, int'(ALU_DIV), 1, 16'h00F9, 16'd2, 0);
        applyStimulus(8, int'(ALU_MOD), 0, 16'd66, 16'd4, 0);
        applyStimulus(8, int'(ALU_DIV), 0, 16'd100, 16'd0, 0);
        applyStimulus(8, int'(ALU_MOD), 1, 16'h00F9, 16'd0, 0);
        applyStimulus(8, int'(ALU_DIV), 1, 16'h0080, 16'h00FF, 0);
        applyStimulus(8, int'(ALU_ADD), 0, 16'd3, 16'd4, 0);
        applyStimulus(16, int'(ALU_MUL), 0, 16'd300, 16'd300, 0);
        applyStimulus(16, int'(ALU_DIV), 0, 16'd65, 16'd4, 0);
        applyStimulus(16, int'(ALU_DIV), 1, 16'hFFF9, 16'd2, 0);
        applyStimulus(16, int'(ALU_MOD), 0, 16'd66, 16'd4, 0);
        applyStimulus(16, int'(ALU_DIV), 1, 16'h8000, 16'hFFFF, 1);

        // A second request waits with in_valid high while the first result is held.
        currentCase = "backpressure";
        driveInputs(8, 1, int'(ALU_MUL), 0, 16'd7, 16'd9);
        @(posedge clk); #1;
        driveInputs(8, 1, int'(ALU_DIV), 0, 16'd200, 16'd7);
        waitResult(8, 10);
        checkResult(8, int'(ALU_MUL), 0, 16'd7, 16'd9);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            readOutputs(8, vld, rdy, rr, rh, dz, of, il);
            checkOutput("bp_hold_valid", vld, 1);
            checkOutput("bp_hold_ready", rdy, 0);
            checkOutput("bp_hold_r", rr, 16'd63);
        end
        retire(8);
        @(posedge clk); #1;
        driveInputs(8, 0, int'(ALU_ADD), 0, 16'h0, 16'h0);
        currentCase = "backpressure_queued";
        waitResult(8, 10);
        checkResult(8, int'(ALU_DIV), 0, 16'd200, 16'd7);
        retire(8);

        // Reset during the fourth CALC cycle abandons the operation.
        currentCase = "reset_mid_op";
        driveInputs(8, 1, int'(ALU_MUL), 0, 16'd200, 16'd200);
        @(posedge clk); #1;
        driveInputs(8, 0, int'(ALU_ADD), 0, 16'h0, 16'h0);
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        readOutputs(8, vld, rdy, rr, rh, dz, of, il);
        checkOutput("mid_rst_in_ready", rdy, 1);
        checkOutput("mid_rst_out_valid", vld, 0);
        checkOutput("mid_rst_r", rr, 0);
        checkOutput("mid_rst_r_high", rh, 0);
        checkOutput("mid_rst_flags", {dz, of, il}, 3'b000);
        #2 rst_n = 1'b1;
        repeat (12) begin @(posedge clk); #1; end
        readOutputs(8, vld, rdy, rr, rh, dz, of, il);
        checkOutput("post_rst_no_output", vld, 0);
        applyStimulus(8, int'(ALU_DIV), 1, 16'h009C, 16'h0005, 0);

        for (int n = 0; n < 80; n++) begin
            w = (n % 2 == 0) ? 8 : 16;
            applyStimulus(w, pickOp(), 1'($urandom_range(0, 1)), pickOperand(w), pickOperand(w),
                          int'($urandom_range(0, 2)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
